// File: rtl/datapath_pkg.sv
// ----------------------------------------------------------------------------
// datapath_pkg : shared width, ALU op and bus-source encodings
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package datapath_pkg;

  localparam int WIDTH   = 32;
  localparam int NUM_GPR = 16;
  localparam int NUM_OPS = 13;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_MUL  = 4'd5,
    OP_DIV  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SHRA = 4'd8,
    OP_SHL  = 4'd9,
    OP_ROR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_NEG  = 4'd12,
    OP_NOT  = 4'd13
  } alu_op_e;

  typedef enum logic [3:0] {
    SEL_GPR  = 4'd0,
    SEL_HI   = 4'd1,
    SEL_LO   = 4'd2,
    SEL_ZHI  = 4'd3,
    SEL_ZLO  = 4'd4,
    SEL_PC   = 4'd5,
    SEL_IR   = 4'd6,
    SEL_MDR  = 4'd7,
    SEL_IN   = 4'd8,
    SEL_C    = 4'd9,
    SEL_Y    = 4'd10,
    SEL_MAR  = 4'd11,
    SEL_NONE = 4'd15
  } bus_sel_e;

  // Strobe bit NUM_OPS-1 is AND (highest priority) down to bit 0 = NOT.
  function automatic alu_op_e decode_alu_op(input logic [NUM_OPS-1:0] strobes);
    alu_op_e op;
    op = OP_NONE;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (strobes[i]) op = alu_op_e'(4'(NUM_OPS - i));
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/datapath_if.sv
// ----------------------------------------------------------------------------
// datapath_if : control strobes, memory input and bus/PC observation
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface datapath_if;
  import datapath_pkg::*;

  // Bit n of Rout/Rin corresponds to register Rn.
  logic [NUM_GPR-1:0] Rout;
  logic [NUM_GPR-1:0] Rin;
  logic HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
  logic Read, IncPC;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin;
  logic [WIDTH-1:0] IN;
  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] PC;

  modport master (
    output Rout, Rin, HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout,
           Cout, Yout, MARout, Read, IncPC,
           AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
           HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, IN,
    input  BusMuxOut, PC
  );

  modport slave (
    input  Rout, Rin, HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout,
           Cout, Yout, MARout, Read, IncPC,
           AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
           HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, IN,
    output BusMuxOut, PC
  );

endinterface

`default_nettype wire

// File: rtl/datapath_alu.sv
// ----------------------------------------------------------------------------
// datapath_alu : combinational 32x32 -> 64-bit ALU (A = Y, B = bus)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module datapath_alu
  import datapath_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  alu_op_e            op,
  output logic [2*WIDTH-1:0] result
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quo;
  logic signed [WIDTH-1:0]   rem;
  logic        [WIDTH-1:0]   shra;
  logic        [4:0]         sh;
  logic        [5:0]         sh_inv;

  always_comb begin
    a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext  = {{WIDTH{b[WIDTH-1]}}, b};
    prod   = a_ext * b_ext;
    sh     = b[4:0];
    sh_inv = 6'd32 - {1'b0, sh};
    shra   = $signed(a) >>> sh;

    // Divide-by-zero returns all-ones quotient and the dividend as remainder.
    if (b == '0) begin
      quo = '1;
      rem = a;
    end else begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end

    result = '0;
    case (op)
      OP_AND:  result = {{WIDTH{1'b0}}, a & b};
      OP_OR:   result = {{WIDTH{1'b0}}, a | b};
      OP_ADD:  result = {{WIDTH{1'b0}}, a + b};
      OP_SUB:  result = {{WIDTH{1'b0}}, a - b};
      OP_MUL:  result = prod;
      OP_DIV:  result = {rem, quo};
      OP_SHR:  result = {{WIDTH{1'b0}}, a >> sh};
      OP_SHRA: result = {{WIDTH{1'b0}}, shra};
      OP_SHL:  result = {{WIDTH{1'b0}}, a << sh};
      // Shift by 32 yields zero, so rotate-by-0 collapses cleanly to A.
      OP_ROR:  result = {{WIDTH{1'b0}}, (a >> sh) | (a << sh_inv)};
      OP_ROL:  result = {{WIDTH{1'b0}}, (a << sh) | (a >> sh_inv)};
      OP_NEG:  result = {{WIDTH{1'b0}}, WIDTH'(0) - b};
      OP_NOT:  result = {{WIDTH{1'b0}}, ~b};
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/datapath.sv
// ----------------------------------------------------------------------------
// datapath : single-bus 32-bit CPU datapath with register file, PC, IR, Y, Z
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module datapath
  import datapath_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  datapath_if.slave  dp
);

  logic [WIDTH-1:0]   gpr [NUM_GPR];
  logic [WIDTH-1:0]   hi, lo, pc, ir, y, mar, mdr;
  logic [2*WIDTH-1:0] z;

  bus_sel_e           sel;
  logic [3:0]         gpr_idx;
  logic [WIDTH-1:0]   bus_val;
  logic [WIDTH-1:0]   c_ext;
  alu_op_e            op;
  logic [2*WIDTH-1:0] alu_res;

  assign c_ext = {{(WIDTH-19){ir[18]}}, ir[18:0]};

  // Walk from lowest to highest priority so the highest asserted select wins.
  always_comb begin
    sel     = SEL_NONE;
    gpr_idx = '0;
    if (dp.MARout)   sel = SEL_MAR;
    if (dp.Yout)     sel = SEL_Y;
    if (dp.Cout)     sel = SEL_C;
    if (dp.INout)    sel = SEL_IN;
    if (dp.MDRout)   sel = SEL_MDR;
    if (dp.IRout)    sel = SEL_IR;
    if (dp.PCout)    sel = SEL_PC;
    if (dp.Zlowout)  sel = SEL_ZLO;
    if (dp.Zhighout) sel = SEL_ZHI;
    if (dp.LOout)    sel = SEL_LO;
    if (dp.HIout)    sel = SEL_HI;
    for (int i = NUM_GPR - 1; i >= 0; i--) begin
      if (dp.Rout[i]) begin
        sel     = SEL_GPR;
        gpr_idx = 4'(i);
      end
    end
  end

  always_comb begin
    bus_val = '0;
    case (sel)
      SEL_GPR: bus_val = gpr[gpr_idx];
      SEL_HI:  bus_val = hi;
      SEL_LO:  bus_val = lo;
      SEL_ZHI: bus_val = z[2*WIDTH-1:WIDTH];
      SEL_ZLO: bus_val = z[WIDTH-1:0];
      SEL_PC:  bus_val = pc;
      SEL_IR:  bus_val = ir;
      SEL_MDR: bus_val = mdr;
      SEL_IN:  bus_val = dp.IN;
      SEL_C:   bus_val = c_ext;
      SEL_Y:   bus_val = y;
      SEL_MAR: bus_val = mar;
      default: bus_val = '0;
    endcase
  end

  assign op = decode_alu_op({dp.AND, dp.OR, dp.ADD, dp.SUB, dp.MUL, dp.DIV, dp.SHR,
                             dp.SHRA, dp.SHL, dp.ROR, dp.ROL, dp.NEG, dp.NOT});

  datapath_alu u_alu (
    .a      (y),
    .b      (bus_val),
    .op     (op),
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      hi  <= '0;
      lo  <= '0;
      pc  <= '0;
      ir  <= '0;
      y   <= '0;
      z   <= '0;
      mar <= '0;
      mdr <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (dp.Rin[i]) gpr[i] <= bus_val;
      end
      if (dp.HIin)  hi  <= bus_val;
      if (dp.LOin)  lo  <= bus_val;
      if (dp.IRin)  ir  <= bus_val;
      if (dp.Yin)   y   <= bus_val;
      if (dp.MARin) mar <= bus_val;
      if (dp.Zin)   z   <= alu_res;
      if (dp.MDRin) mdr <= dp.Read ? dp.IN : bus_val;
      // Increment outranks a bus load into PC.
      if (dp.IncPC)     pc <= pc + WIDTH'(1);
      else if (dp.PCin) pc <= bus_val;
    end
  end

  assign dp.BusMuxOut = bus_val;
  assign dp.PC        = pc;

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ----------------------------------------------------------------------------
// tb_datapath : directed scoreboard bench for the single-bus datapath
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_datapath;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  datapath_if dif ();

  datapath dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dif.slave)
  );

  // Strobe masks in {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT} order
  localparam logic [12:0] M_NONE = 13'h0000;
  localparam logic [12:0] M_AND  = 13'h1000;
  localparam logic [12:0] M_OR   = 13'h0800;
  localparam logic [12:0] M_ADD  = 13'h0400;
  localparam logic [12:0] M_SUB  = 13'h0200;
  localparam logic [12:0] M_MUL  = 13'h0100;
  localparam logic [12:0] M_DIV  = 13'h0080;
  localparam logic [12:0] M_SHRA = 13'h0020;
  localparam logic [12:0] M_ROL  = 13'h0004;
  localparam logic [12:0] M_NEG  = 13'h0002;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic clear_ctrl();
    dif.Rout = '0;  dif.Rin = '0;
    dif.HIout = 0; dif.LOout = 0; dif.Zhighout = 0; dif.Zlowout = 0; dif.PCout = 0;
    dif.IRout = 0; dif.MDRout = 0; dif.INout = 0; dif.Cout = 0; dif.Yout = 0; dif.MARout = 0;
    dif.Read = 0; dif.IncPC = 0;
    {dif.AND, dif.OR, dif.ADD, dif.SUB, dif.MUL, dif.DIV, dif.SHR,
     dif.SHRA, dif.SHL, dif.ROR, dif.ROL, dif.NEG, dif.NOT} = '0;
    dif.HIin = 0; dif.LOin = 0; dif.PCin = 0; dif.IRin = 0; dif.Zin = 0;
    dif.Yin = 0; dif.MARin = 0; dif.MDRin = 0;
    dif.IN = '0;
  endtask

  task automatic set_ops(input logic [12:0] v);
    {dif.AND, dif.OR, dif.ADD, dif.SUB, dif.MUL, dif.DIV, dif.SHR,
     dif.SHRA, dif.SHL, dif.ROR, dif.ROL, dif.NEG, dif.NOT} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h required none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) else begin
        fails++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic mdr_from_in(input logic [31:0] v);
    clear_ctrl();
    dif.IN = v; dif.Read = 1; dif.MDRin = 1;
    tick();
    clear_ctrl();
  endtask

  task automatic load_gpr(input int n, input logic [31:0] v);
    mdr_from_in(v);
    dif.MDRout = 1; dif.Rin[n] = 1;
    tick();
    clear_ctrl();
  endtask

  task automatic read_gpr(input int n, input string tag, input logic [31:0] v);
    clear_ctrl();
    expect_val(tag, v);
    dif.Rout[n] = 1;
    #1;
    check(dif.BusMuxOut);
    clear_ctrl();
  endtask

  // k: 0 HI, 1 LO, 2 Zhigh, 3 Zlow, 4 IR, 5 MDR, 6 Y, 7 MAR, 8 PC, 9 C
  task automatic read_special(input int k, input string tag, input logic [31:0] v);
    clear_ctrl();
    expect_val(tag, v);
    case (k)
      0: dif.HIout = 1;
      1: dif.LOout = 1;
      2: dif.Zhighout = 1;
      3: dif.Zlowout = 1;
      4: dif.IRout = 1;
      5: dif.MDRout = 1;
      6: dif.Yout = 1;
      7: dif.MARout = 1;
      8: dif.PCout = 1;
      default: dif.Cout = 1;
    endcase
    #1;
    check(dif.BusMuxOut);
    clear_ctrl();
  endtask

  task automatic alu_run(input logic [12:0] ops, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mdr_from_in(a);
    dif.MDRout = 1; dif.Yin = 1;
    tick();
    clear_ctrl();
    dif.IN = b; dif.INout = 1; set_ops(ops); dif.Zin = 1;
    tick();
    read_special(3, {tag, "_lo"}, exp_lo);
    read_special(2, {tag, "_hi"}, exp_hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_ctrl();
    reset = 1;
    tick();
    tick();
    reset = 0;

    expect_val("reset_pc", 32'h0);
    check(dif.PC);
    expect_val("idle_bus", 32'h0);
    check(dif.BusMuxOut);

    // SHRA walk-through: R4 <= R3 >>> R7
    load_gpr(3, 32'hF0005022);
    load_gpr(7, 32'h00000008);
    mdr_from_in(32'h521B8000);
    dif.MDRout = 1; dif.IRin = 1;
    tick();
    clear_ctrl();
    dif.Rout[3] = 1; dif.Yin = 1;
    tick();
    clear_ctrl();
    dif.Rout[7] = 1; set_ops(M_SHRA); dif.Zin = 1;
    tick();
    clear_ctrl();
    dif.Zlowout = 1; dif.Rin[4] = 1;
    expect_val("shra_bus", 32'hFFF00050);
    #1;
    check(dif.BusMuxOut);
    tick();
    clear_ctrl();
    read_gpr(4, "shra_r4", 32'hFFF00050);
    read_special(4, "ir_load", 32'h521B8000);

    // ALU operations
    alu_run(M_ROL, 32'hF0005022, 32'h8, "rol", 32'h0, 32'h005022F0);
    alu_run(M_MUL, 32'hFFFFFFFE, 32'h3, "mul", 32'hFFFFFFFF, 32'hFFFFFFFA);
    alu_run(M_DIV, 32'h28, 32'h8, "div", 32'h0, 32'h5);
    alu_run(M_DIV, 32'h7, 32'h0, "div0", 32'h7, 32'hFFFFFFFF);
    alu_run(M_DIV, 32'hFFFFFFF9, 32'h2, "divneg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    alu_run(M_ADD, 32'hFFFFFFFF, 32'h2, "add", 32'h0, 32'h1);
    alu_run(M_SUB, 32'h3, 32'h5, "sub", 32'h0, 32'hFFFFFFFE);
    alu_run(M_AND | M_OR, 32'h0000F0F0, 32'h0000FF00, "and_prio", 32'h0, 32'h0000F000);
    alu_run(M_NEG, 32'h12345678, 32'h1, "neg", 32'h0, 32'hFFFFFFFF);
    alu_run(M_NONE, 32'h12345678, 32'h1, "noop", 32'h0, 32'h0);

    // Bus source priority: R1 outranks MAR
    load_gpr(1, 32'h0000AAAA);
    mdr_from_in(32'h00005555);
    dif.MDRout = 1; dif.MARin = 1;
    tick();
    clear_ctrl();
    expect_val("bus_prio", 32'h0000AAAA);
    dif.Rout[1] = 1; dif.MARout = 1;
    #1;
    check(dif.BusMuxOut);
    clear_ctrl();
    read_special(7, "mar_load", 32'h00005555);

    // Constant sign extension from IR[18:0]
    mdr_from_in(32'h0007FFFF);
    dif.MDRout = 1; dif.IRin = 1;
    tick();
    read_special(9, "cout_neg", 32'hFFFFFFFF);
    mdr_from_in(32'h0003FFFF);
    dif.MDRout = 1; dif.IRin = 1;
    tick();
    read_special(9, "cout_pos", 32'h0003FFFF);

    // PC increment, precedence and wrap
    reset = 1;
    tick();
    reset = 0;
    clear_ctrl();
    dif.IncPC = 1;
    tick(); tick(); tick();
    expect_val("pc_inc3", 32'h3);
    check(dif.PC);
    dif.IN = 32'h100; dif.INout = 1; dif.PCin = 1;
    tick();
    expect_val("pc_inc_wins", 32'h4);
    check(dif.PC);
    clear_ctrl();
    dif.IN = 32'h100; dif.INout = 1; dif.PCin = 1;
    tick();
    expect_val("pc_load", 32'h100);
    check(dif.PC);
    clear_ctrl();
    dif.IN = 32'hFFFFFFFF; dif.INout = 1; dif.PCin = 1;
    tick();
    clear_ctrl();
    dif.IncPC = 1;
    tick();
    expect_val("pc_wrap", 32'h0);
    check(dif.PC);
    clear_ctrl();

    // Populate registers, then reset with every load enable active
    for (int i = 0; i < 16; i++) load_gpr(i, 32'hA000_0000 + 32'(i));
    mdr_from_in(32'h0BADF00D);
    dif.MDRout = 1; dif.HIin = 1; dif.LOin = 1; dif.Yin = 1; dif.MARin = 1;
    dif.IRin = 1; dif.PCin = 1;
    tick();
    clear_ctrl();
    set_ops(M_MUL); dif.Zin = 1; dif.MDRout = 1;
    tick();
    clear_ctrl();
    dif.Rin = '1;
    dif.HIin = 1; dif.LOin = 1; dif.PCin = 1; dif.IRin = 1; dif.Zin = 1;
    dif.Yin = 1; dif.MARin = 1; dif.MDRin = 1;
    dif.Read = 1; dif.IncPC = 1; dif.IN = 32'h1234; dif.INout = 1;
    set_ops(M_ADD);
    reset = 1;
    tick();
    reset = 0;
    clear_ctrl();
    expect_val("rst_bus_idle", 32'h0);
    #1;
    check(dif.BusMuxOut);
    expect_val("rst_pc", 32'h0);
    check(dif.PC);
    for (int i = 0; i < 16; i++) read_gpr(i, $sformatf("rst_r%0d", i), 32'h0);
    for (int k = 0; k < 8; k++) read_special(k, $sformatf("rst_src%0d", k), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath: sixteen general registers R0–R15, PC, IR, HI, LO, Y, 64-bit Z, MAR and MDR, all sharing one internal bus (BusMuxOut).
- An external control unit or bench drives one-hot "out" selects, "in" load enables and ALU operation strobes each clock.
- The ALU combines Y (operand A) with the bus (operand B) and writes the 64-bit result into Z.

Parameters:
- WIDTH, 32, data/register width (Z is 2*WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears every register.
- R0out..R15out  in  1 each  drive Rn onto bus.
- HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout  in  1 each  bus source selects.
- Read  in  1  MDR input mux: 1 = IN (memory data), 0 = bus.
- IncPC  in  1  PC <= PC+1.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  in  1 each  ALU op strobes.
- R0in..R15in, HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin  in  1 each  register load enables.
- IN  in  32  memory-data / input-port word.
- BusMuxOut  out  32  current bus value.
- PC  out  32  program counter contents.

Behaviour:
- Bus (combinational):
  - Value is the selected source.
  - Cout drives sign-extended IR[18:0].
  - INout drives IN.
  - Zhighout/Zlowout drive Z[63:32] and Z[31:0].
  - If several selects are asserted, fixed priority applies: R0..R15, HI, LO, Zhigh, Zlow, PC, IR, MDR, IN, C, Y, MAR.
  - With no select asserted, the bus is 0.
- Register loads:
  - All registers update on posedge clk; load value is BusMuxOut when the enable is high, otherwise the register holds.
  - MDR loads IN if Read=1, else the bus (MDRin still required).
- PC: IncPC=1 gives PC <= PC+1 (wraps 0xFFFFFFFF->0) and takes precedence over PCin. PCin alone gives PC <= bus.
- Reset: when reset=1 at posedge, every register (R0–R15, HI, LO, PC, IR, Y, Z, MAR, MDR) goes to 0, overriding all load enables and IncPC.
- ALU (combinational, A=Y, B=bus). Z loads the result only when Zin=1. If several op strobes are high, priority is the port order listed. If no strobe is high, the result is 0.
- ALU operation results:
  - AND/OR: Zlow = A&B or A|B; Zhigh = 0.
  - ADD/SUB: Zlow = A+B or A-B, mod 2^32; Zhigh = 0.
  - MUL: Z = signed 64-bit A*B.
  - DIV: signed; Zlow = quotient, Zhigh = remainder (sign follows dividend). For B=0: Zlow=0xFFFFFFFF, Zhigh=A.
  - SHR/SHRA/SHL/ROR/ROL: A shifted or rotated by B[4:0]. SHRA replicates A[31]. Zhigh = 0.
  - NEG: Zlow = -B. NOT: Zlow = ~B. Zhigh = 0 for both.
- Latency:
  - Source to destination register: 1 clock.
  - Y, then op into Z, then Z to register: 3 clocks.
- A register that is both bus source and destination in the same cycle loads its own old value.
- No handshakes; Read has no wait states.

Decomposition:
- Shared package: WIDTH, ALU op encoding enum, bus-select encoding enum.
- One sub-module, datapath_alu: combinational 32x32 to 64-bit ALU.
- The bus encoder and registers stay inline.

Test Plan:
- SHRA: reset; load R3=0xF0005022, R7=0x00000008 via Read/MDRin then MDRout/Rnin; IR<=0x521B8000; R3out+Yin; R7out+SHRA+Zin; Zlowout+R4in -> R4=0xFFF00050, BusMuxOut=0xFFF00050 during the last step.
- ROL: Y=0xF0005022, bus=8 -> Zlow=0x005022F0, Zhigh=0.
- MUL/DIV:
  - Y=0xFFFFFFFE, bus=3, MUL -> Z=0xFFFFFFFF_FFFFFFFA.
  - Y=0x28, bus=8, DIV -> Zlow=5, Zhigh=0.
  - Y=7, bus=0, DIV -> Zlow=0xFFFFFFFF, Zhigh=7.
- PC: reset, then IncPC for 3 cycles -> PC=3. IncPC+PCin with bus=0x100 -> PC=4 (IncPC wins).
- Reset priority: assert reset with every *in=1 and IN=0x1234 -> all registers 0 next cycle; bus=0 with no selects.
- Cout: IR=0x0007FFFF -> Cout gives bus=0xFFFFFFFF. IR=0x0003FFFF -> bus=0x0003FFFF.
